prog_loader_m: RTL

- Boot-time program loader that sits directly upstream of the CPU core and its instruction/data memory.
- Accepts a byte stream over a valid/ready handshake and writes each byte into consecutive memory locations starting at address 0.
- Holds the CPU in reset while loading, then releases it and runs until the CPU asserts halt.
- Reports completion, overflow error and a run-cycle count to the test environment.

---
 rtl/prog_loader_m.sv | 134 +++++++++++++
 1 files changed

// File: rtl/prog_loader_m.sv
// prog_loader_m: boot-time program loader. It streams bytes into memory from
// address 0 and holds the CPU in reset while loading. It then releases the CPU
// and counts run clocks until the CPU halts.
// Optional build macro: PROG_LOADER_FILL_EN. When defined, memory past the end
// of the program is zero-filled before the CPU is released.
module prog_loader_m #(
  parameter int DW = 8,
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          start,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wr,
  output logic          cpu_rst_,
  input  logic          halt,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [CW-1:0] run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
`ifdef PROG_LOADER_FILL_EN
    S_FILL = 3'd2,
`endif
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Pointer carries one extra bit so "memory completely written" is ptr[AW].
  localparam logic [AW:0] LAST_ADDR = {1'b0, {AW{1'b1}}};

  state_t      state, state_nx;
  logic [AW:0] ptr;
  logic        term;      // terminating beat accepted, its write is in flight
  logic        term_ovf;  // that terminating beat was an overflow
  logic        accept;
  logic        start_ok;

  assign accept   = in_valid && in_ready;
  assign start_ok = start && (state == S_IDLE || state == S_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state, handshake ready and busy decode.
  always_comb begin
    state_nx = state;
    in_ready = (state == S_LOAD) && !term;
    busy     = (state == S_LOAD) || (state == S_RUN);
`ifdef PROG_LOADER_FILL_EN
    busy     = busy || (state == S_FILL);
`endif
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_LOAD;
      // Leave LOAD only after the terminating beat's write cycle.
      S_LOAD: if (term) begin
        if (term_ovf)     state_nx = S_IDLE;
`ifdef PROG_LOADER_FILL_EN
        else if (!ptr[AW]) state_nx = S_FILL;
`endif
        else              state_nx = S_RUN;
      end
`ifdef PROG_LOADER_FILL_EN
      // The last zero write is issued on the edge that sets ptr[AW]. Wait one
      // more cycle so that write lands before the CPU comes out of reset.
      S_FILL: if (ptr[AW]) state_nx = S_RUN;
`endif
      S_RUN:  if (halt) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: memory write port, pointer, status flags and run counter.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      cpu_rst_   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      run_cycles <= '0;
      ptr        <= '0;
      term       <= 1'b0;
      term_ovf   <= 1'b0;
    end else begin
      mem_wr   <= 1'b0;
      // Registered from next state so cpu_rst_ drops on the restart edge.
      cpu_rst_ <= (state_nx == S_RUN) || (state_nx == S_DONE);
      done     <= (state_nx == S_DONE);
      if (start_ok) begin
        ptr        <= '0;
        term       <= 1'b0;
        term_ovf   <= 1'b0;
        error      <= 1'b0;
        run_cycles <= '0;
      end
      if (accept) begin
        mem_wr   <= 1'b1;
        mem_addr <= ptr[AW-1:0];
        mem_data <= in_data;
        ptr      <= ptr + (AW+1)'(1);
        term     <= in_last || (ptr == LAST_ADDR);
        term_ovf <= !in_last && (ptr == LAST_ADDR);
      end
      if (state == S_LOAD && term && term_ovf) error <= 1'b1;
`ifdef PROG_LOADER_FILL_EN
      if (state == S_FILL && !ptr[AW]) begin
        mem_wr   <= 1'b1;
        mem_addr <= ptr[AW-1:0];
        mem_data <= '0;
        ptr      <= ptr + (AW+1)'(1);
      end
`endif
      // The halting clock is not counted; the counter saturates.
      if (state == S_RUN && !halt && run_cycles != {CW{1'b1}})
        run_cycles <= run_cycles + CW'(1);
    end
  end

endmodule
